mac_dot_scheduler: RTL and testbench
====================================

Name: mac_dot_scheduler

Overview:
Sequencer that runs one dot-product job at a time on the 16-bit MAC unit (booth multiplier plus Kogge-Stone accumulator).
- Accepts a job length, streams operand pairs into the MAC, and counts returned products.
- Issues finalize, captures the accumulated result, and presents it on a valid/ready result port.
- Sits between the operand-fetch logic and one MAC instance; the MAC itself is unchanged.

Parameters:
- LEN_W, 8, width of job length; max job = 2^LEN_W-1 pairs.
- TIMEOUT, 64, watchdog limit in cycles (used only when SCHED_TIMEOUT_EN is defined).

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- start, input, 1, job request; sampled only in IDLE.
- len, input, LEN_W, number of operand pairs; sampled with start.
- busy, output, 1, high whenever state != IDLE.
- op_valid, input, 1, operand pair valid.
- op_ready, output, 1, scheduler accepts a pair.
- op_a, input, 16, signed operand A.
- op_b, input, 16, signed operand B.
- mac_clr, output, 1, active-high clear pulse to the MAC reset.
- mac_en, output, 1, MAC multiply enable.
- mac_a, output, 16, MAC operand A.
- mac_b, output, 16, MAC operand B.
- mac_mult_valid, input, 1, product-valid strobe from the MAC.
- mac_finalize, output, 1, finalize pulse to the MAC.
- mac_out, input, 32, signed MAC result.
- mac_out_valid, input, 1, MAC result valid.
- res_valid, output, 1, result available.
- res_ready, input, 1, consumer accepts the result.
- res_data, output, 32, signed dot-product result.
- res_err, output, 1, job aborted by watchdog; qualified by res_valid.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; issue_cnt, done_cnt, len_q and the watchdog cleared. A reset in any state abandons the job with no result.
- All outputs are registered.
- IDLE:
  - start=1 with len!=0: latch len_q=len, clear both counters, go to CLEAR.
  - start=1 with len==0: res_data=0, res_err=0, go to HOLD; the MAC is not touched.
  - start is ignored in every other state.
- CLEAR: mac_clr=1 for exactly one cycle, then FEED.
- FEED:
  - op_ready=1 while issue_cnt<len_q.
  - On a transfer (op_valid & op_ready) at edge t: mac_en=1, mac_a=op_a, mac_b=op_b during cycle t+1; issue_cnt++.
  - With no transfer, mac_en=0 and mac_a/mac_b hold their last value.
  - At most one pair is transferred per cycle.
  - When the transfer brings issue_cnt to len_q: op_ready=0 from the next cycle, go to DRAIN.
- Product counting:
  - done_cnt increments on every mac_mult_valid pulse seen in FEED or DRAIN.
  - Pulses in any other state are ignored.
  - done_cnt saturates at len_q.
- DRAIN: when done_cnt==len_q, go to FINAL. This holds even if done_cnt already reached len_q in FEED.
- FINAL: mac_finalize=1 for exactly one cycle, then WAIT_OUT. By then the MAC accumulator already holds the last sum.
- WAIT_OUT: on mac_out_valid=1, res_data=mac_out, res_err=0, go to HOLD.
- HOLD:
  - res_valid=1; res_data and res_err are held stable until res_ready=1.
  - On the res_valid & res_ready edge: res_valid=0, go to IDLE.
  - A start in that same cycle is not accepted; it must be presented again in IDLE.
- Arithmetic: the scheduler performs no arithmetic on data; the MAC wraps modulo 2^32 and the scheduler passes the result through unchanged.
- Back-pressure: gaps on op_valid stall FEED indefinitely; no timeout applies in FEED.

Optional Feature:
Macro SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in DRAIN or WAIT_OUT and clears on every state change.
  - When it reaches TIMEOUT: res_data=0, res_err=1, go to HOLD.
  - The MAC is left uncleared; the next job's CLEAR resets it.
- Undefined: no watchdog logic; res_err is tied 0; DRAIN and WAIT_OUT wait forever.

Test Plan:
- Basic job: len=3, pairs (2,3), (-4,5), (7,-1) with op_valid held high. Required: three mac_en pulses, one mac_clr before them, one mac_finalize after the third mac_mult_valid, then res_valid=1 with res_data=-21 and res_err=0.
- Back-pressure: len=4, pairs (1,1), (2,2), (3,3), (4,4) with one idle cycle between op_valid pulses. Required: op_ready drops after the 4th transfer; res_data=30; mac_en pulses align 1 cycle after each transfer.
- Zero length: start with len=0. Required: no mac_clr, mac_en or mac_finalize; res_valid=1 with res_data=0 within 2 cycles.
- Result hold: complete a len=1 job of (-32768,-32768) with res_ready=0 for 10 cycles. Required: res_data=0x40000000 stable with res_valid=1 throughout; start pulses during hold ignored; IDLE one cycle after res_ready=1.
- Mid-job reset: assert rst=0 after 2 of 5 transfers. Required: all outputs 0 immediately; busy=0. A following len=2 job of (3,3), (1,1) returns res_data=10.
- Watchdog (SCHED_TIMEOUT_EN defined, TIMEOUT=64): len=2 with the MAC model never asserting mac_mult_valid. Required: res_valid=1, res_err=1, res_data=0 exactly 64 cycles after entering DRAIN.

Source files
------------

// File: rtl/mac_dot_scheduler_if.sv
// rtl/mac_dot_scheduler_if.sv - job, operand, MAC and result signals of the dot-product scheduler
interface mac_dot_scheduler_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;

  logic             op_valid;
  logic             op_ready;
  logic [15:0]      op_a;
  logic [15:0]      op_b;

  logic             mac_clr;
  logic             mac_en;
  logic [15:0]      mac_a;
  logic [15:0]      mac_b;
  logic             mac_mult_valid;
  logic             mac_finalize;
  logic [31:0]      mac_out;
  logic             mac_out_valid;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic             res_err;

  modport slave (
    input  start, len, op_valid, op_a, op_b,
    input  mac_mult_valid, mac_out, mac_out_valid, res_ready,
    output busy, op_ready, mac_clr, mac_en, mac_a, mac_b,
    output mac_finalize, res_valid, res_data, res_err
  );

  modport master (
    output start, len, op_valid, op_a, op_b,
    output mac_mult_valid, mac_out, mac_out_valid, res_ready,
    input  busy, op_ready, mac_clr, mac_en, mac_a, mac_b,
    input  mac_finalize, res_valid, res_data, res_err
  );
endinterface

// File: rtl/mac_dot_scheduler.sv
// rtl/mac_dot_scheduler.sv - sequences one dot-product job on a 16-bit MAC
// Optional DRAIN/WAIT_OUT watchdog is enabled by defining SCHED_TIMEOUT_EN.
module mac_dot_scheduler #(
  parameter int LEN_W = 8
`ifdef SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input logic                clk,
  input logic                rst,
  mac_dot_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_FINAL,
    S_WAIT_OUT,
    S_HOLD
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issue_cnt;
  logic [LEN_W-1:0] done_cnt;

  logic             busy_q;
  logic             op_ready_q;
  logic             mac_clr_q;
  logic             mac_en_q;
  logic             mac_finalize_q;
  logic             res_valid_q;
  logic [15:0]      mac_a_q;
  logic [15:0]      mac_b_q;
  logic [31:0]      res_data_q;

  logic [31:0]      res_data_nx;
  logic             res_load;
  logic             job_go;
  logic             xfer;
  logic             issue_last;
  logic             count_prod;

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0]  wdog;
  logic             timeout_hit;
  logic             res_err_q;
  logic             res_err_nx;
`endif

  assign job_go     = (state == S_IDLE) && bus.start;
  assign xfer       = (state == S_FEED) && op_ready_q && bus.op_valid;
  assign issue_last = xfer && ((issue_cnt + LEN_W'(1)) == len_q);
  // Products are only meaningful while this job owns the MAC.
  assign count_prod = ((state == S_FEED) || (state == S_DRAIN)) &&
                      bus.mac_mult_valid && (done_cnt != len_q);

  always_comb begin
    state_nx    = state;
    res_load    = 1'b0;
    res_data_nx = res_data_q;
`ifdef SCHED_TIMEOUT_EN
    res_err_nx  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            state_nx = S_CLEAR;
          end else begin
            state_nx    = S_HOLD;
            res_load    = 1'b1;
            res_data_nx = 32'd0;
          end
        end
      end
      S_CLEAR: state_nx = S_FEED;
      S_FEED: begin
        if (issue_last) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (done_cnt == len_q) begin
          state_nx = S_FINAL;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (timeout_hit) begin
          state_nx    = S_HOLD;
          res_load    = 1'b1;
          res_data_nx = 32'd0;
          res_err_nx  = 1'b1;
        end
`endif
      end
      S_FINAL: state_nx = S_WAIT_OUT;
      S_WAIT_OUT: begin
        if (bus.mac_out_valid) begin
          state_nx    = S_HOLD;
          res_load    = 1'b1;
          res_data_nx = bus.mac_out;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (timeout_hit) begin
          state_nx    = S_HOLD;
          res_load    = 1'b1;
          res_data_nx = 32'd0;
          res_err_nx  = 1'b1;
        end
`endif
      end
      S_HOLD: begin
        if (bus.res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Control outputs are registered copies of the next state, so each one
  // is high for exactly the cycles spent in the matching state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q         <= 1'b0;
      op_ready_q     <= 1'b0;
      mac_clr_q      <= 1'b0;
      mac_finalize_q <= 1'b0;
      res_valid_q    <= 1'b0;
    end else begin
      busy_q         <= (state_nx != S_IDLE);
      op_ready_q     <= (state_nx == S_FEED);
      mac_clr_q      <= (state_nx == S_CLEAR);
      mac_finalize_q <= (state_nx == S_FINAL);
      res_valid_q    <= (state_nx == S_HOLD);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_en_q <= 1'b0;
      mac_a_q  <= 16'd0;
      mac_b_q  <= 16'd0;
    end else begin
      mac_en_q <= xfer;
      if (xfer) begin
        mac_a_q <= bus.op_a;
        mac_b_q <= bus.op_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q     <= '0;
      issue_cnt <= '0;
      done_cnt  <= '0;
    end else if (job_go) begin
      if (bus.len != '0) len_q <= bus.len;
      issue_cnt <= '0;
      done_cnt  <= '0;
    end else begin
      if (xfer)       issue_cnt <= issue_cnt + LEN_W'(1);
      if (count_prod) done_cnt  <= done_cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_data_q <= 32'd0;
    end else if (res_load) begin
      res_data_q <= res_data_nx;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  assign timeout_hit = ((state == S_DRAIN) || (state == S_WAIT_OUT)) &&
                       (wdog == WD_W'(TIMEOUT - 1));

  // Restarts on every state change so DRAIN and WAIT_OUT each get a full budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog <= '0;
    end else if (state_nx != state) begin
      wdog <= '0;
    end else if ((state == S_DRAIN) || (state == S_WAIT_OUT)) begin
      wdog <= wdog + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_err_q <= 1'b0;
    end else if (res_load) begin
      res_err_q <= res_err_nx;
    end
  end

  assign bus.res_err = res_err_q;
`else
  assign bus.res_err = 1'b0;
`endif

  assign bus.busy         = busy_q;
  assign bus.op_ready     = op_ready_q;
  assign bus.mac_clr      = mac_clr_q;
  assign bus.mac_en       = mac_en_q;
  assign bus.mac_a        = mac_a_q;
  assign bus.mac_b        = mac_b_q;
  assign bus.mac_finalize = mac_finalize_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;

endmodule

// File: tb/tb_mac_dot_scheduler.sv
// tb/tb_mac_dot_scheduler.sv - scoreboard bench for mac_dot_scheduler with a behavioural MAC
module tb_mac_dot_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_dot_scheduler_if #(.LEN_W(8)) bus ();

  mac_dot_scheduler #(.LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } res_t;

  res_t                exp_q[$];
  res_t                sb_r;
  logic signed [15:0]  pa[$];
  logic signed [15:0]  pb[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_clr, n_en, n_fin;
  int clr_cyc, first_en_cyc, fin_cyc, mv_cyc, last_xfer_cyc;

  logic op_ready_s = 1'b0;
  logic exp_en = 1'b0;
  logic en_chk = 1'b0;
  logic [15:0] exp_a, exp_b;
  logic mac_mute = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural MAC: two-stage product pipeline, result two cycles after finalize.
  logic               p_v, f_v;
  logic signed [31:0] p, acc;
  always @(posedge clk) begin
    if (!rst) begin
      p_v <= 1'b0; f_v <= 1'b0; p <= 32'sd0; acc <= 32'sd0;
      bus.mac_mult_valid <= 1'b0; bus.mac_out_valid <= 1'b0; bus.mac_out <= 32'd0;
    end else begin
      p_v <= bus.mac_en;
      p   <= $signed(bus.mac_a) * $signed(bus.mac_b);
      bus.mac_mult_valid <= p_v && !mac_mute;
      if (bus.mac_clr) acc <= 32'sd0;
      else if (p_v && !mac_mute) acc <= acc + p;
      f_v <= bus.mac_finalize;
      bus.mac_out_valid <= f_v;
      if (f_v) bus.mac_out <= acc;
    end
  end

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    exp_en = rst && bus.op_valid && op_ready_s;
    exp_a  = bus.op_a;
    exp_b  = bus.op_b;
  end

  always @(negedge clk) begin
    op_ready_s = bus.op_ready;
    if (rst) begin
      if (bus.mac_clr) begin n_clr++; clr_cyc = cyc; end
      if (bus.mac_en) begin n_en++; if (first_en_cyc < 0) first_en_cyc = cyc; end
      if (bus.mac_finalize) begin n_fin++; fin_cyc = cyc; end
      if (bus.mac_mult_valid) mv_cyc = cyc;
      if (en_chk) begin
        check("mac_en_align", bus.mac_en, exp_en);
        if (exp_en) check("mac_ab", {bus.mac_a, bus.mac_b}, {exp_a, exp_b});
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 1, 0);
        end else begin
          sb_r = exp_q.pop_front();
          check("res_data", bus.res_data, sb_r.data);
          check("res_err", bus.res_err, sb_r.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    n_clr = 0; n_en = 0; n_fin = 0;
    clr_cyc = -1; first_en_cyc = -1; fin_cyc = -1; mv_cyc = -1;
    pa.delete(); pb.delete();
  endtask

  task automatic add(input int a, input int b);
    pa.push_back(16'(a));
    pb.push_back(16'(b));
  endtask

  function automatic logic [31:0] dot();
    logic signed [31:0] s, t;
    s = 32'sd0;
    foreach (pa[i]) begin
      t = pa[i];
      t = t * pb[i];
      s = s + t;
    end
    return s;
  endfunction

  task automatic push_exp(input logic [31:0] d, input logic e);
    res_t r;
    r.data = d;
    r.err  = e;
    exp_q.push_back(r);
  endtask

  task automatic start_job(input int l);
    bus.start = 1'b1;
    bus.len   = 8'(l);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed(input int gap, input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      bus.op_valid = 1'b1;
      bus.op_a = pa[i];
      bus.op_b = pb[i];
      @(negedge clk);
      while (!bus.op_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("feed_ready", w < 50, 1);
      tick();
      last_xfer_cyc = cyc;
      bus.op_valid = 1'b0;
      if (gap != 0) tick();
    end
  endtask

  task automatic wait_valid(input string tag);
    int w;
    w = 0;
    while (!bus.res_valid && w < 400) begin
      @(negedge clk);
      w++;
    end
    check(tag, w < 400, 1);
  endtask

  task automatic wait_result();
    bus.res_ready = 1'b1;
    wait_valid("res_arrive");
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    rst = 1'b0;
    bus.start = 1'b0; bus.len = 8'd0; bus.op_valid = 1'b0;
    bus.op_a = 16'd0; bus.op_b = 16'd0; bus.res_ready = 1'b1;
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {bus.busy, bus.op_ready, bus.mac_clr, bus.mac_en,
                      bus.mac_finalize, bus.res_valid, bus.res_err}, 0);
    check("rst_data", bus.res_data, 0);
    check("rst_mac_ab", {bus.mac_a, bus.mac_b}, 0);
    rst = 1'b1;
    en_chk = 1'b1;
    tick();

    // Basic job, op_valid held high
    clr_stats();
    add(2, 3); add(-4, 5); add(7, -1);
    check("basic_model", dot(), 32'hFFFF_FFEB);
    push_exp(dot(), 1'b0);
    start_job(3);
    feed(0, 3);
    wait_result();
    check("basic_en_cnt", n_en, 3);
    check("basic_clr_cnt", n_clr, 1);
    check("basic_fin_cnt", n_fin, 1);
    check("basic_clr_first", clr_cyc < first_en_cyc, 1);
    check("basic_fin_after_mv", fin_cyc > mv_cyc, 1);
    check("basic_idle", bus.busy, 0);

    // Back-pressure: idle cycle between operand pairs
    clr_stats();
    add(1, 1); add(2, 2); add(3, 3); add(4, 4);
    push_exp(32'd30, 1'b0);
    start_job(4);
    feed(1, 4);
    check("bp_ready_drop", bus.op_ready, 0);
    wait_result();
    check("bp_en_cnt", n_en, 4);

    // Zero length: result without touching the MAC
    clr_stats();
    push_exp(32'd0, 1'b0);
    bus.res_ready = 1'b0;
    start_job(0);
    @(negedge clk);
    check("zero_valid", bus.res_valid, 1);
    check("zero_data", bus.res_data, 0);
    wait_result();
    check("zero_mac_touch", n_clr + n_en + n_fin, 0);

    // Result hold with starts presented while HOLD
    clr_stats();
    add(-32768, -32768);
    push_exp(32'h4000_0000, 1'b0);
    bus.res_ready = 1'b0;
    start_job(1);
    feed(0, 1);
    wait_valid("hold_arrive");
    for (int i = 0; i < 10; i++) begin
      bus.start = 1'b1;
      bus.len = 8'd3;
      tick();
      check("hold_valid", bus.res_valid, 1);
      check("hold_data", bus.res_data, 32'h4000_0000);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    check("hold_idle_busy", bus.busy, 0);
    check("hold_valid_drop", bus.res_valid, 0);
    tick();
    check("hold_start_ignored", bus.busy, 0);
    check("hold_clr_cnt", n_clr, 1);

    // Mid-job reset after 2 of 5 transfers
    clr_stats();
    add(1, 2); add(3, 4); add(5, 6); add(7, 8); add(9, 10);
    start_job(5);
    feed(0, 2);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_ctl", {bus.busy, bus.op_ready, bus.mac_clr, bus.mac_en,
                          bus.mac_finalize, bus.res_valid, bus.res_err}, 0);
    check("mid_rst_data", {bus.res_data, bus.mac_a, bus.mac_b}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    clr_stats();
    add(3, 3); add(1, 1);
    push_exp(32'd10, 1'b0);
    start_job(2);
    feed(0, 2);
    wait_result();

`ifdef SCHED_TIMEOUT_EN
    // Watchdog: MAC never reports products
    clr_stats();
    mac_mute = 1'b1;
    add(5, 6); add(7, 8);
    push_exp(32'd0, 1'b1);
    bus.res_ready = 1'b0;
    start_job(2);
    feed(0, 2);
    t0 = last_xfer_cyc;
    wait_valid("wdog_arrive");
    check("wdog_delay", cyc - t0, 64);
    bus.res_ready = 1'b1;
    tick();
    mac_mute = 1'b0;
    tick();
`else
    t0 = 0;
`endif

    tick();
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
